// File: rtl/mem_stage_ls.sv
// Memory-access stage: byte/half/word loads and stores against a local data RAM,
// optional wait states with StallM, MEM/WB register. Optional: MEM_MISALIGN_TRAP_EN.
module mem_stage_ls #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RdM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PcPlus4M,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PcPlus4W,
    output logic        MisalignW
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state, nextState;
    logic [3:0]  wcnt, wcntNext;
    logic        stallInt, complete, access, misalign, memWe;
    logic [3:0]  byteEn;
    logic [31:0] wdata, rdWord, loadExt, loadData;
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    logic [AW-1:0] wordIdx;
    logic [1:0]  byteOff;
    logic        unusedAddr;

    logic [31:0] mem [DEPTH];

    assign wordIdx    = ALUResultM[AW+1:2];
    assign byteOff    = ALUResultM[1:0];
    assign unusedAddr = ^ALUResultM[31:AW+2];
    assign access     = MemReadM | MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = access &&
                      ((((Funct3M == 3'b001) || (Funct3M == 3'b101)) && ALUResultM[0]) ||
                       ((Funct3M == 3'b010) && (byteOff != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        nextState = state;
        wcntNext  = wcnt;
        stallInt  = 1'b0;
        complete  = 1'b0;
        case (state)
            S_IDLE: begin
                // misaligned traps complete immediately, never enter wait states
                if (access && !misalign && (WAIT_STATES != 0)) begin
                    stallInt  = 1'b1;
                    nextState = S_WAIT;
                    wcntNext  = 4'(WAIT_STATES - 1);
                end else begin
                    complete = 1'b1;
                end
            end
            S_WAIT: begin
                if (wcnt != 4'd0) begin
                    stallInt = 1'b1;
                    wcntNext = wcnt - 4'd1;
                end else begin
                    complete  = 1'b1;
                    nextState = S_IDLE;
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

    assign StallM = stallInt & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= nextState;
            wcnt  <= wcntNext;
        end
    end

    always_comb begin
        byteEn = 4'b0000;
        wdata  = WriteDataM;
        case (Funct3M)
            3'b000: begin
                byteEn = 4'b0001 << byteOff;
                wdata  = {4{WriteDataM[7:0]}};
            end
            3'b001: begin
                byteEn = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{WriteDataM[15:0]}};
            end
            3'b010:  byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    // rst gating keeps a store that is in flight during reset from committing
    assign memWe = complete & MemWriteM & ~misalign & rst;

    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdWord = mem[wordIdx];
    assign rdByte = rdWord[{byteOff, 3'b000} +: 8];
    assign rdHalf = ALUResultM[1] ? rdWord[31:16] : rdWord[15:0];

    always_comb begin
        case (Funct3M)
            3'b000:  loadExt = {{24{rdByte[7]}}, rdByte};
            3'b001:  loadExt = {{16{rdHalf[15]}}, rdHalf};
            3'b010:  loadExt = rdWord;
            3'b100:  loadExt = {24'd0, rdByte};
            3'b101:  loadExt = {16'd0, rdHalf};
            default: loadExt = 32'd0;
        endcase
    end

    assign loadData = (MemReadM && !MemWriteM && !misalign) ? loadExt : 32'd0;

    // MEM/WB: real instruction on the completing cycle, bubble while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'd0;
            RdW        <= 5'd0;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            PcPlus4W   <= 32'd0;
            MisalignW  <= 1'b0;
        end else if (complete) begin
            RegWriteW  <= RegWriteM & ~misalign;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= loadData;
            PcPlus4W   <= PcPlus4M;
            MisalignW  <= misalign;
        end else begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'd0;
            RdW        <= 5'd0;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            PcPlus4W   <= 32'd0;
            MisalignW  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage_ls.sv
// Randomized bench for mem_stage_ls (WAIT_STATES=2) against a word-array reference model.
module tb_mem_stage_ls;
    localparam int WS    = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteM = 0, MemWriteM = 0, MemReadM = 0;
    logic [1:0]  ResultSrcM = 0;
    logic [2:0]  Funct3M = 0;
    logic [4:0]  RdM = 0;
    logic [31:0] ALUResultM = 0, WriteDataM = 0, PcPlus4M = 0;
    logic        StallM, RegWriteW, MisalignW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW, ReadDataW, PcPlus4W;

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl [DEPTH];

    mem_stage_ls #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RdM(RdM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PcPlus4M(PcPlus4M),
        .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PcPlus4W(PcPlus4W),
        .MisalignW(MisalignW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit misOf(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return (((f3 == 3'd1) || (f3 == 3'd5)) && (a % 2 != 0)) || ((f3 == 3'd2) && (a % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w, b, h;
        w = mdl[(a / 4) % DEPTH];
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic storeModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int idx;
        logic [31:0] mask, val;
        idx = int'((a / 4) % DEPTH);
        case (f3)
            3'd0: begin mask = 32'hFF << (8 * (a % 4));         val = (d & 32'hFF) << (8 * (a % 4)); end
            3'd1: begin mask = 32'hFFFF << (16 * ((a / 2) % 2)); val = (d & 32'hFFFF) << (16 * ((a / 2) % 2)); end
            3'd2: begin mask = 32'hFFFFFFFF;                     val = d; end
            default: return;
        endcase
        mdl[idx] = (mdl[idx] & ~mask) | val;
    endtask

    task automatic doOp(input logic rw, input logic mw, input logic mr, input logic [1:0] rs,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] pc);
        bit mis;
        int nStall;
        logic [31:0] expRd;
        mis    = misOf(f3, a) && (mw || mr);
        nStall = ((mw || mr) && !mis) ? WS : 0;
        expRd  = (mr && !mw && !mis) ? loadModel(f3, a) : 32'd0;
        @(negedge clk);
        RegWriteM = rw; MemWriteM = mw; MemReadM = mr; ResultSrcM = rs;
        Funct3M = f3; RdM = rd; ALUResultM = a; WriteDataM = wd; PcPlus4M = pc;
        #1;
        for (int k = 0; k < nStall; k++) begin
            chk("stall", StallM, 1);
            @(posedge clk); #1;
            chk("bubbleRegWrite", RegWriteW, 0);
            chk("bubbleRd", RdW, 0);
            chk("bubbleRead", ReadDataW, 0);
        end
        chk("stallDone", StallM, 0);
        @(posedge clk); #1;
        chk("RegWriteW", RegWriteW, rw && !mis);
        chk("ResultSrcW", ResultSrcW, rs);
        chk("RdW", RdW, rd);
        chk("ALUResultW", ALUResultW, a);
        chk("ReadDataW", ReadDataW, expRd);
        chk("PcPlus4W", PcPlus4W, pc);
        chk("MisalignW", MisalignW, mis);
        if (mw && !mis) storeModel(f3, a, wd);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "Stall"}, StallM, 0);
        chk({tag, "RegWrite"}, RegWriteW, 0);
        chk({tag, "ResultSrc"}, ResultSrcW, 0);
        chk({tag, "Rd"}, RdW, 0);
        chk({tag, "ALUResult"}, ALUResultW, 0);
        chk({tag, "ReadData"}, ReadDataW, 0);
        chk({tag, "PcPlus4"}, PcPlus4W, 0);
        chk({tag, "Misalign"}, MisalignW, 0);
    endtask

    initial begin
        // held in reset with a live-looking load on the inputs
        RegWriteM = 1; MemReadM = 1; RdM = 5'd7; ALUResultM = 32'h44; PcPlus4M = 32'h100; ResultSrcM = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        chkAllZero("rst");
        @(negedge clk);
        RegWriteM = 0; MemReadM = 0; RdM = 0; ALUResultM = 0; PcPlus4M = 0; ResultSrcM = 0;
        rst = 1;

        for (int i = 0; i < 16; i++)
            doOp(0, 1, 0, 0, 3'd2, 0, 32'(i * 4), $urandom, 32'(i));

        doOp(0, 1, 0, 0, 3'd2, 0, 32'h10, 32'hDEADBEEF, 32'h4);
        doOp(1, 0, 1, 2'd1, 3'd0, 5'd3, 32'h13, 0, 32'h8);
        chk("lb", ReadDataW, 32'hFFFFFFDE);
        doOp(1, 0, 1, 2'd1, 3'd4, 5'd3, 32'h13, 0, 32'hC);
        chk("lbu", ReadDataW, 32'h000000DE);
        doOp(1, 0, 1, 2'd1, 3'd1, 5'd4, 32'h10, 0, 32'h10);
        chk("lh", ReadDataW, 32'hFFFFBEEF);
        doOp(1, 0, 1, 2'd1, 3'd5, 5'd4, 32'h10, 0, 32'h14);
        chk("lhu", ReadDataW, 32'h0000BEEF);

        doOp(0, 1, 0, 0, 3'd2, 0, 32'h20, 32'h0, 32'h18);
        doOp(0, 1, 0, 0, 3'd0, 0, 32'h21, 32'hFFFFFF5A, 32'h1C);
        doOp(1, 0, 1, 2'd1, 3'd2, 5'd5, 32'h20, 0, 32'h20);
        chk("sbLw", ReadDataW, 32'h00005A00);

        doOp(1, 0, 0, 2'd0, 3'd0, 5'd9, 32'h77, 0, 32'h24);

        doOp(0, 1, 0, 0, 3'd2, 0, 32'h1000, 32'h12345678, 32'h28);
        doOp(1, 0, 1, 2'd1, 3'd2, 5'd6, 32'h0, 0, 32'h2C);
        chk("wrap", ReadDataW, 32'h12345678);

        doOp(0, 1, 0, 0, 3'd2, 0, 32'h20, 32'h0, 32'h30);
        doOp(1, 1, 0, 0, 3'd2, 5'd8, 32'h22, 32'hA5A5A5A5, 32'h34);
        doOp(1, 0, 1, 2'd1, 3'd2, 5'd6, 32'h20, 0, 32'h38);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("misalignKept", ReadDataW, 32'h0);
`else
        chk("alignedWrite", ReadDataW, 32'hA5A5A5A5);
`endif

        // reset on the second stall cycle of a store aborts it
        @(negedge clk);
        RegWriteM = 0; MemWriteM = 1; MemReadM = 0; Funct3M = 3'd2;
        ALUResultM = 32'h30; WriteDataM = 32'hCAFEF00D; PcPlus4M = 32'h3C;
        #1;
        chk("midStall1", StallM, 1);
        @(posedge clk); #1;
        chk("midStall2", StallM, 1);
        rst = 0;
        #1;
        chkAllZero("midRst");
        @(negedge clk);
        MemWriteM = 0; ALUResultM = 0; WriteDataM = 0; PcPlus4M = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        doOp(1, 0, 1, 2'd1, 3'd2, 5'd10, 32'h30, 0, 32'h40);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ((32'($urandom) % 4) << 12) | ((32'($urandom) % 16) << 2) | (32'($urandom) % 4);
            doOp(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
                 5'($urandom), a, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
